fpu_add_arbiter: RTL
====================

# fpu_add_arbiter

Round-robin controller that shares one pipelined floating-point add datapath (unpack → add → normalize stages, fixed latency) among NREQ requesters. It accepts operand pairs over valid/ready, issues at most one operation per cycle into the datapath, and tags each operation with its requester ID through a shadow pipeline. It returns each result with the originating ID and provides a flush/drain sequence. It sits between the requesters and the FPU pipeline top.

## Interface
- NREQ, 4, number of requesters (2..8)
- LAT, 3, fixed datapath latency in cycles from fpu_valid_o to fpu_valid_i (≥1)
- IDW, $clog2(NREQ), requester ID width (derived, not overridden)

- clk_i  in  1  clock; single clock domain, all logic on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  NREQ  per-requester operation valid
- req_a_i  in  NREQ*32  operand A per requester (IEEE-754 single, requester i at [32i+31:32i])
- req_b_i  in  NREQ*32  operand B per requester
- req_ready_o  out  NREQ  one-hot grant; handshake when req_valid_i[i] & req_ready_o[i]
- fpu_valid_o  out  1  issue strobe to datapath
- fpu_a_o, fpu_b_o  out  32 each  operands to datapath
- fpu_valid_i  in  1  result strobe from datapath
- fpu_res_i  in  32  result from datapath
- res_valid_o  out  1  result valid to requesters (no backpressure)
- res_id_o  out  IDW  originating requester
- res_data_o  out  32  result
- flush_i  in  1  request drain
- flush_done_o  out  1  one-cycle pulse when drain completes
- busy_o  out  1  in-flight count ≠ 0
- err_o  out  1  sticky tag/strobe mismatch flag

## Operation
- Reset values: all outputs 0; RR pointer = NREQ-1 (requester 0 wins first); in-flight count 0; state RUN; tag pipeline cleared.
- Arbitration (combinational, state RUN and flush_i=0): grant lowest-index valid requester searching from pointer+1 modulo NREQ; req_ready_o one-hot or zero. Pointer updates to granted index on handshake only.
- Issue: on handshake, fpu_valid_o/fpu_a_o/fpu_b_o registered next cycle; grant ID enters tag shift register (depth LAT+1, valid+ID per stage) aligned with fpu_valid_o.
- Return: on fpu_valid_i, res_valid_o/res_data_o/res_id_o registered next cycle, ID from tag stage aligned to fpu_valid_i.
- Mismatch: fpu_valid_i ≠ aligned tag valid sets err_o; cleared only by reset. On mismatch with fpu_valid_i=1 and no tag, result still emitted with res_id_o=0.
- In-flight count: +1 on handshake, −1 on res_valid_o; both in same cycle → unchanged. Width $clog2(LAT+3).
- FSM:
  - RUN: grants enabled. flush_i=1 → DRAIN; no grant in that cycle.
  - DRAIN: no grants; in-flight = 0 → DONE.
  - DONE: flush_done_o=1 for exactly one cycle; → RUN. flush_i ignored in DRAIN/DONE.
- flush_i while already empty: RUN→DRAIN→DONE, pulse 2 cycles after flush_i.
- Reset mid-operation: in-flight ops discarded; later fpu_valid_i with empty tag pipe sets err_o.

## Timing
- Handshake cycle T → fpu_valid_o at T+1 → fpu_valid_i at T+1+LAT → res_valid_o at T+2+LAT (total LAT+2).
- Throughput: one issue per cycle; back-to-back grants rotate among all asserted requesters.
- req_ready_o depends combinationally on req_valid_i, state, flush_i; no other combinational input-to-output paths.

## Configuration
- FPU_ARB_STATS_EN defined: adds output op_count_o [15:0], counting handshakes, saturating at 16'hFFFF, reset 0, cleared in the DONE cycle.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Single op: requester 2 sends A=0x3F800000, B=0x40000000 (datapath model returns 0x40400000) → res_valid_o at T+LAT+2, res_id_o=2, res_data_o=0x40400000.
- Fairness: all 4 requesters hold valid for 8 cycles → grant order 0,1,2,3,0,1,2,3; no requester granted twice before others.
- Back-to-back: requester 1 streams 5 ops consecutively → 5 consecutive res_valid_o, all id 1, in issue order; busy_o high throughout, low after last.
- Flush: 3 ops in flight, flush_i pulsed → no grants until flush_done_o pulses exactly 1 cycle after last res_valid_o; grants resume next cycle.
- Mismatch: inject fpu_valid_i with no issued op → err_o=1 and stays set until rst_ni low.
- Reset mid-stream: assert rst_ni low asynchronously with 2 ops in flight → all outputs 0 immediately; after release, requester 0 granted first.

Source files
------------

// File: rtl/fpu_add_arbiter.sv
// Round-robin issue arbiter sharing one fixed-latency FP add pipeline, with a requester-ID shadow pipe and flush/drain.
// Define FPU_ARB_STATS_EN to add op_count_o, a saturating handshake counter cleared when a drain completes.
module fpu_add_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 3,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [NREQ*32-1:0]   req_a_i,
    input  logic [NREQ*32-1:0]   req_b_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic                 fpu_valid_o,
    output logic [31:0]          fpu_a_o,
    output logic [31:0]          fpu_b_o,
    input  logic                 fpu_valid_i,
    input  logic [31:0]          fpu_res_i,
    output logic                 res_valid_o,
    output logic [IDW-1:0]       res_id_o,
    output logic [31:0]          res_data_o,
    input  logic                 flush_i,
    output logic                 flush_done_o,
    output logic                 busy_o,
    output logic                 err_o
`ifdef FPU_ARB_STATS_EN
    ,
    output logic [15:0]          op_count_o
`endif
);
    localparam int CW = $clog2(LAT + 3);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e          state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  grant_id;
    logic            grant_found;
    logic [NREQ-1:0] grant;
    logic [31:0]     sel_a;
    logic [31:0]     sel_b;
    logic [LAT:0]    tag_v;
    logic [IDW-1:0]  tag_id [LAT+1];
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   inflight_next;

    // Handshake: requester i transfers an operand pair in any cycle where
    // req_valid_i[i] && req_ready_o[i]; ready never waits on anything but
    // valid, state and flush_i, and at most one ready bit is high.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        if (rst_ni && state == RUN && !flush_i) begin
            // Indices above the pointer first, then wrap to the low indices.
            for (int k = 0; k < NREQ; k++) begin
                if (!grant_found && req_valid_i[k] && IDW'(k) > rr_ptr) begin
                    grant_found = 1'b1;
                    grant_id    = IDW'(k);
                end
            end
            for (int k = 0; k < NREQ; k++) begin
                if (!grant_found && req_valid_i[k] && IDW'(k) <= rr_ptr) begin
                    grant_found = 1'b1;
                    grant_id    = IDW'(k);
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_found && grant_id == IDW'(k)) begin
                grant[k] = 1'b1;
                sel_a    = req_a_i[32*k +: 32];
                sel_b    = req_b_i[32*k +: 32];
            end
        end
    end

    assign req_ready_o = grant;

    // A stray result on an empty count must not wrap the counter.
    always_comb begin
        inflight_next = inflight;
        if (grant_found && !res_valid_o) begin
            inflight_next = inflight + CW'(1);
        end else if (!grant_found && res_valid_o && inflight != '0) begin
            inflight_next = inflight - CW'(1);
        end
    end

    assign busy_o = (inflight != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= RUN;
            rr_ptr       <= IDW'(NREQ - 1);
            fpu_valid_o  <= 1'b0;
            fpu_a_o      <= '0;
            fpu_b_o      <= '0;
            tag_v        <= '0;
            for (int k = 0; k <= LAT; k++) begin
                tag_id[k] <= '0;
            end
            res_valid_o  <= 1'b0;
            res_id_o     <= '0;
            res_data_o   <= '0;
            err_o        <= 1'b0;
            inflight     <= '0;
            flush_done_o <= 1'b0;
        end else begin
            fpu_valid_o <= grant_found;
            if (grant_found) begin
                rr_ptr  <= grant_id;
                fpu_a_o <= sel_a;
                fpu_b_o <= sel_b;
            end

            // Stage k holds the tag for the op whose fpu_valid_o was k cycles ago.
            tag_v     <= {tag_v[LAT-1:0], grant_found};
            tag_id[0] <= grant_id;
            for (int k = 1; k <= LAT; k++) begin
                tag_id[k] <= tag_id[k-1];
            end

            res_valid_o <= fpu_valid_i;
            if (fpu_valid_i) begin
                res_data_o <= fpu_res_i;
                res_id_o   <= tag_v[LAT] ? tag_id[LAT] : '0;
            end
            if (fpu_valid_i != tag_v[LAT]) begin
                err_o <= 1'b1;
            end

            inflight <= inflight_next;

            case (state)
                RUN: begin
                    flush_done_o <= 1'b0;
                    if (flush_i) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Looking at the next count lets the pulse land one cycle after the last result.
                    if (inflight_next == '0) begin
                        state        <= DONE;
                        flush_done_o <= 1'b1;
                    end
                end
                DONE: begin
                    state        <= RUN;
                    flush_done_o <= 1'b0;
                end
                default: begin
                    state        <= RUN;
                    flush_done_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef FPU_ARB_STATS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_count_o <= '0;
        end else if (state == DONE) begin
            op_count_o <= '0;
        end else if (grant_found && op_count_o != 16'hFFFF) begin
            op_count_o <= op_count_o + 16'd1;
        end
    end
`endif

endmodule
